// File: rtl/hdmi_mode_programmer.sv
// hdmi_mode_programmer: writes an 8-word timing set plus frame base (or base only) into the HDMI slave window.
module hdmi_mode_programmer #(
  parameter logic [9:0] C_TIMING_OFFSET = 10'h004,
  parameter logic [9:0] C_BASE_OFFSET   = 10'h00C,
  parameter int         C_WRITE_GAP     = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CFG_START,
  input  logic        FLIP_START,
  input  logic [15:0] H_ACT_START,
  input  logic [15:0] H_ACT_END,
  input  logic [15:0] V_ACT_START,
  input  logic [15:0] V_ACT_END,
  input  logic [15:0] H_SYNC_END,
  input  logic [15:0] V_SYNC_END,
  input  logic [15:0] H_TOTAL,
  input  logic [15:0] V_TOTAL,
  input  logic [31:0] FRAME_BASE,
  output logic        WE,
  output logic [9:0]  WADDR,
  output logic [31:0] WDATA,
  input  logic        WREADY,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);
  typedef enum logic [2:0] {IDLE, TIMING, GAP, BASE, FINISH} state_t;
  state_t state, state_n, ret, ret_n, tgt;
  logic [2:0] cnt, cnt_n;
  logic [3:0] gcnt, gcnt_n;
  logic [15:0] tw [8];
  logic [31:0] base;
  logic err_n, start, ok, acc;
  assign start = state == IDLE && (CFG_START || FLIP_START);
  // A flip only needs a valid base; a config also needs non-empty active regions.
  assign ok = FRAME_BASE[31] && ((FLIP_START && !CFG_START) ||
              (H_ACT_END > H_ACT_START && V_ACT_END > V_ACT_START));
  assign WE = state == TIMING || state == BASE;
  assign acc = WE && WREADY;
  assign WADDR = state == TIMING ? C_TIMING_OFFSET : state == BASE ? C_BASE_OFFSET : '0;
  assign WDATA = state == TIMING ? {16'h0, tw[cnt]} : state == BASE ? base : '0;
  assign BUSY = state != IDLE && state != FINISH;
  assign DONE = state == FINISH;
  always_comb begin
    tgt = state == TIMING ? (cnt == 3'd7 ? BASE : TIMING) : FINISH;
    state_n = state;
    ret_n = ret;
    cnt_n = cnt;
    gcnt_n = gcnt;
    err_n = ERR;
    case (state)
      IDLE: if (start) begin
        err_n = !ok;
        cnt_n = '0;
        state_n = !ok ? FINISH : CFG_START ? TIMING : BASE;
      end
      TIMING, BASE: if (acc) begin
        cnt_n = state == TIMING ? cnt + 3'd1 : cnt;
        ret_n = tgt;
        gcnt_n = '0;
        state_n = C_WRITE_GAP == 0 ? tgt : GAP;
      end
      GAP: begin
        gcnt_n = gcnt + 4'd1;
        state_n = gcnt == 4'(C_WRITE_GAP - 1) ? ret : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ret <= IDLE;
      cnt <= '0;
      gcnt <= '0;
      ERR <= 1'b0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      cnt <= cnt_n;
      gcnt <= gcnt_n;
      ERR <= err_n;
    end
  end
  // Word order matches the slave shift register: word0 ends up at index 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tw <= '{default: '0};
      base <= '0;
    end else if (start) begin
      tw <= '{V_ACT_END, H_ACT_END, V_ACT_START, H_ACT_START,
              V_SYNC_END, H_SYNC_END, V_TOTAL, H_TOTAL};
      base <= FRAME_BASE;
    end
  end
endmodule

// File: tb/tb_hdmi_mode_programmer.sv
// tb_hdmi_mode_programmer: table-driven sequences with a write scoreboard and a slave shift-register model.
module tb_hdmi_mode_programmer;
  localparam logic [9:0] TOFF = 10'h004;
  localparam logic [9:0] BOFF = 10'h00C;
  typedef struct {
    bit cfg, flip;
    logic [15:0] hs, he, vs, ve, hse, vse, ht, vt;
    logic [31:0] base;
    bit err;
    int done, nw;
  } vec_t;
  logic clk = 0, rst = 1, cfg = 0, flip = 0, cfg2 = 0, wready = 1;
  logic [15:0] hs = 0, he = 0, vs = 0, ve = 0, hse = 0, vse = 0, ht = 0, vt = 0;
  logic [31:0] fb = 0, wdata, wdata2;
  logic [9:0] waddr, waddr2;
  logic we, busy, done, err, we2, busy2, done2, err2;
  int nchk = 0, nfail = 0, nwr = 0;
  bit mon_en = 1;
  logic [41:0] sbq [$];
  logic [31:0] slv [8];
  logic stall = 0;
  logic [41:0] stall_w;
  vec_t tbl [9];

  always #5 clk = ~clk;

  hdmi_mode_programmer dut (
    .CLK(clk), .RST(rst), .CFG_START(cfg), .FLIP_START(flip),
    .H_ACT_START(hs), .H_ACT_END(he), .V_ACT_START(vs), .V_ACT_END(ve),
    .H_SYNC_END(hse), .V_SYNC_END(vse), .H_TOTAL(ht), .V_TOTAL(vt),
    .FRAME_BASE(fb), .WE(we), .WADDR(waddr), .WDATA(wdata), .WREADY(wready),
    .BUSY(busy), .DONE(done), .ERR(err)
  );

  hdmi_mode_programmer #(.C_WRITE_GAP(2)) dut_gap (
    .CLK(clk), .RST(rst), .CFG_START(cfg2), .FLIP_START(1'b0),
    .H_ACT_START(hs), .H_ACT_END(he), .V_ACT_START(vs), .V_ACT_END(ve),
    .H_SYNC_END(hse), .V_SYNC_END(vse), .H_TOTAL(ht), .V_TOTAL(vt),
    .FRAME_BASE(fb), .WE(we2), .WADDR(waddr2), .WDATA(wdata2), .WREADY(1'b1),
    .BUSY(busy2), .DONE(done2), .ERR(err2)
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Slave side: every accepted write is popped from the scoreboard and shifted into the timing model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall) begin
        chk("held_write", {21'h0, we, waddr, wdata}, {21'h0, 1'b1, stall_w});
      end
      stall = we && !wready;
      stall_w = {waddr, wdata};
      if (we && wready) begin
        nwr++;
        if (sbq.size() == 0) chk("unexpected_write", {waddr, wdata}, 42'h0);
        else chk("write", {22'h0, waddr, wdata}, {22'h0, sbq.pop_front()});
        if (waddr == TOFF) begin
          for (int i = 0; i < 7; i++) slv[i] = slv[i + 1];
          slv[7] = wdata;
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    hs = v.hs; he = v.he; vs = v.vs; ve = v.ve;
    hse = v.hse; vse = v.vse; ht = v.ht; vt = v.vt; fb = v.base;
  endtask

  task automatic push(input vec_t v);
    logic [15:0] w [8];
    w = '{v.ve, v.he, v.vs, v.hs, v.vse, v.hse, v.vt, v.ht};
    if (!v.err) begin
      if (v.cfg) for (int i = 0; i < 8; i++) sbq.push_back({TOFF, 16'h0, w[i]});
      sbq.push_back({BOFF, v.base});
    end
  endtask

  task automatic run(input string n, input vec_t v, input logic [63:0] mask, input bit poke);
    int cyc, dcyc, ndone, n0;
    push(v);
    @(posedge clk); #1;
    drive(v);
    cfg = v.cfg; flip = v.flip;
    @(posedge clk); #1;
    cfg = 0; flip = 0;
    hs = 0; he = 0; vs = 0; ve = 0; fb = ~v.base;
    n0 = nwr; cyc = 1; dcyc = 0; ndone = 0;
    wready = !mask[1];
    while (cyc < 60 && (dcyc == 0 || cyc < dcyc + 3)) begin
      if (poke && cyc == 3) begin cfg = 1; flip = 1; end
      @(negedge clk);
      if (cyc == 1) begin
        chk({n, "_err_c1"}, 64'(err), 64'(v.err));
        chk({n, "_busy_c1"}, 64'(busy), 64'(!v.err));
      end
      if (done) begin
        ndone++;
        if (dcyc == 0) begin
          dcyc = cyc;
          chk({n, "_err_done"}, 64'(err), 64'(v.err));
          chk({n, "_busy_done"}, 64'(busy), 64'h0);
        end
      end
      @(posedge clk); #1;
      cfg = 0; flip = 0;
      cyc++;
      wready = !mask[cyc];
    end
    wready = 1;
    chk({n, "_done_cycle"}, 64'(dcyc), 64'(v.done));
    chk({n, "_done_count"}, 64'(ndone), 64'h1);
    chk({n, "_writes"}, 64'(nwr - n0), 64'(v.nw));
    chk({n, "_leftover"}, 64'(sbq.size()), 64'h0);
    if (v.cfg && !v.err) begin
      chk({n, "_width"}, 64'(slv[1] - slv[3]), 64'(v.he - v.hs));
      chk({n, "_height"}, 64'(slv[0] - slv[2]), 64'(v.ve - v.vs));
    end
    sbq.delete();
  endtask

  initial begin
    vec_t v;
    int k, n0, bad, d2, nw2;
    logic e;
    tbl[0] = '{1, 0, 0, 1920, 0, 1080, 2052, 1089, 2200, 1125, 32'h8000_0000, 0, 10, 9};
    tbl[1] = '{0, 1, 0, 1920, 0, 1080, 2052, 1089, 2200, 1125, 32'h8040_0000, 0, 2, 1};
    tbl[2] = '{0, 1, 0, 1920, 0, 1080, 2052, 1089, 2200, 1125, 32'h0040_0000, 1, 1, 0};
    tbl[3] = '{1, 0, 100, 100, 0, 1080, 2052, 1089, 2200, 1125, 32'h8000_0000, 1, 1, 0};
    tbl[4] = '{1, 0, 260, 1540, 25, 745, 1580, 750, 1650, 750, 32'h8010_0000, 0, 10, 9};
    tbl[5] = '{1, 1, 0, 1920, 0, 1080, 2052, 1089, 2200, 1125, 32'h8000_0000, 0, 10, 9};
    tbl[6] = '{1, 0, 0, 640, 480, 100, 656, 490, 800, 525, 32'h8000_0000, 1, 1, 0};
    tbl[7] = '{1, 0, 0, 640, 0, 480, 656, 490, 800, 525, 32'h7fff_0000, 1, 1, 0};
    tbl[8] = '{0, 1, 100, 100, 0, 0, 0, 0, 0, 0, 32'h8000_1000, 0, 2, 1};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_we", 64'(we), 0);
    chk("rst_waddr", 64'(waddr), 0);
    chk("rst_wdata", 64'(wdata), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    for (int i = 0; i < 9; i++) run($sformatf("vec%0d", i), tbl[i], 64'h0, 0);
    v = tbl[0]; v.done = 16;
    run("backpressure", v, 64'h70E0, 0);
    run("busy_starts", tbl[0], 64'h0, 1);
    // Reset after the 5th accepted write must abandon the sequence immediately.
    push(tbl[0]);
    @(posedge clk); #1;
    drive(tbl[0]); cfg = 1;
    @(posedge clk); #1;
    cfg = 0; n0 = nwr; k = 0;
    while (nwr - n0 < 5 && k < 40) begin @(posedge clk); k++; end
    chk("rst_seq_timeout", 64'(k < 40), 1);
    #3 rst = 1;
    #1;
    chk("async_we", 64'(we), 0);
    chk("async_busy", 64'(busy), 0);
    chk("async_done", 64'(done), 0);
    sbq.delete();
    @(posedge clk); #1 rst = 0;
    run("after_rst", tbl[0], 64'h0, 0);
    // Gap=2 instance: writes in cycles 1,4,...,25 and DONE in 28.
    mon_en = 0;
    @(posedge clk); #1;
    drive(tbl[0]); cfg2 = 1;
    @(posedge clk); #1;
    cfg2 = 0; bad = 0; d2 = 0; nw2 = 0;
    for (int c = 1; c <= 40 && d2 == 0; c++) begin
      @(negedge clk);
      e = c <= 25 && (c - 1) % 3 == 0;
      if (we2 !== e) bad++;
      if (we2) nw2++;
      if (c == 1) chk("gap_first_data", 64'(wdata2), 64'd1080);
      if (c == 25) chk("gap_base", {22'h0, waddr2, wdata2}, {22'h0, BOFF, 32'h8000_0000});
      if (done2) d2 = c;
      @(posedge clk); #1;
    end
    chk("gap_we_pattern", 64'(bad), 0);
    chk("gap_writes", 64'(nw2), 9);
    chk("gap_done_cycle", 64'(d2), 28);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule
